orientation_histogram_gen: RTL

Parametrised 8-bin gradient-orientation histogram engine for the SIFT descriptor stage. On `start` it scans a PATCH_SIZE×PATCH_SIZE window of the x/y gradient BRAMs, anchored at its top-left corner (x, y), through their read ports. Each gradient sample is classified into one of eight 45° sectors, and the engine accumulates either a count or an L1-magnitude weight per bin. It then reports the flattened histogram and the dominant bin.

---
 rtl/orientation_histogram_gen.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/orientation_histogram_gen.sv
// Eight-bin gradient-orientation histogram over a square patch of the
// gradient BRAMs, with count or L1-weight accumulation and peak-bin search.
module orientation_histogram_gen #(
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 64,
  parameter int BIT_DEPTH    = 8,
  parameter int PATCH_SIZE   = 4,
  parameter int BIN_WIDTH    = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              start,
  input  logic                              weight_mode_in,
  input  logic [$clog2(WIDTH)-1:0]          x,
  input  logic [$clog2(HEIGHT)-1:0]         y,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   x_read_addr,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   y_read_addr,
  input  logic signed [BIT_DEPTH-1:0]       x_grad_in,
  input  logic signed [BIT_DEPTH-1:0]       y_grad_in,
  output logic [8*BIN_WIDTH-1:0]            histogram_out,
  output logic [2:0]                        peak_bin_out,
  output logic                              busy,
  output logic                              histogram_done
);

  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam int AW   = $clog2(WIDTH*HEIGHT);
  localparam int N    = PATCH_SIZE*PATCH_SIZE;
  localparam int CNTW = $clog2(N+1);
  localparam int OFW  = $clog2(PATCH_SIZE)+1;
  localparam int DW   = $clog2(READ_LATENCY+1);
  localparam int SW   = ((BIN_WIDTH > BIT_DEPTH+1) ?
                         BIN_WIDTH : BIT_DEPTH+1) + 1;
  localparam int MAXV = (1 << BIN_WIDTH) - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DRAIN, S_PEAK, S_DONE
  } state_t;

  state_t                r_state;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic                  r_mode;
  logic [OFW-1:0]        r_oc;
  logic [OFW-1:0]        r_or;
  logic [CNTW-1:0]       r_cnt;
  logic [DW-1:0]         r_drain;
  logic [AW-1:0]         r_addr;
  logic [READ_LATENCY:0] r_vld;
  logic [BIN_WIDTH-1:0]  r_bins [8];
  logic [2:0]            r_peak;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_idle;
  logic [XW-1:0]         w_bx;
  logic [YW-1:0]         w_by;
  logic [OFW-1:0]        w_oc;
  logic [OFW-1:0]        w_or;
  logic                  w_wrap;
  logic [31:0]           w_col;
  logic [31:0]           w_row;
  logic                  w_inb;
  logic                  w_issue;

  // In IDLE the first slot is issued straight from the inputs so that
  // slot 0's address is already registered in cycle 1.
  assign w_idle  = (r_state == S_IDLE);
  assign w_bx    = w_idle ? x : r_x;
  assign w_by    = w_idle ? y : r_y;
  assign w_oc    = w_idle ? '0 : r_oc;
  assign w_or    = w_idle ? '0 : r_or;
  assign w_wrap  = (w_oc == OFW'(PATCH_SIZE-1));
  assign w_col   = 32'(w_bx) + 32'(w_oc);
  assign w_row   = 32'(w_by) + 32'(w_or);
  assign w_inb   = (w_col < 32'(WIDTH)) && (w_row < 32'(HEIGHT));
  assign w_issue = (w_idle && start) ||
                   ((r_state == S_SCAN) && (r_cnt != CNTW'(N)));

  logic                  w_xpos;
  logic                  w_xneg;
  logic                  w_ypos;
  logic                  w_yneg;
  logic                  w_nz;
  logic [BIT_DEPTH-1:0]  w_ax;
  logic [BIT_DEPTH-1:0]  w_ay;
  logic [1:0]            w_q;
  logic                  w_s;
  logic [2:0]            w_bin;
  logic [SW-1:0]         w_sum;
  logic [BIN_WIDTH-1:0]  w_sat;

  assign w_xneg = x_grad_in[BIT_DEPTH-1];
  assign w_yneg = y_grad_in[BIT_DEPTH-1];
  assign w_xpos = !w_xneg && (|x_grad_in);
  assign w_ypos = !w_yneg && (|y_grad_in);
  assign w_nz   = (|x_grad_in) || (|y_grad_in);
  assign w_ax   = w_xneg ? BIT_DEPTH'(-x_grad_in) : BIT_DEPTH'(x_grad_in);
  assign w_ay   = w_yneg ? BIT_DEPTH'(-y_grad_in) : BIT_DEPTH'(y_grad_in);

  always_comb begin
    w_q = 2'd0;
    unique case (1'b1)
      (w_xpos && !w_yneg):  w_q = 2'd0;
      (!w_xpos && w_ypos):  w_q = 2'd1;
      (w_xneg && !w_ypos):  w_q = 2'd2;
      (!w_xneg && w_yneg):  w_q = 2'd3;
      default:              w_q = 2'd0;
    endcase
  end

  assign w_s   = w_q[0] ? (w_ax >= w_ay) : (w_ay >= w_ax);
  assign w_bin = {w_q, w_s};
  assign w_sum = SW'(r_bins[w_bin]) +
                 (r_mode ? (SW'(w_ax) + SW'(w_ay)) : SW'(1));
  assign w_sat = (w_sum > SW'(MAXV)) ? '1 : w_sum[BIN_WIDTH-1:0];

  logic [2:0]           w_peak;
  logic [BIN_WIDTH-1:0] w_pmax;

  always_comb begin
    w_peak = 3'd0;
    w_pmax = r_bins[0];
    for (int b = 1; b < 8; b++) begin
      if (r_bins[b] > w_pmax) begin
        w_pmax = r_bins[b];
        w_peak = 3'(b);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_mode  <= 1'b0;
      r_oc    <= '0;
      r_or    <= '0;
      r_cnt   <= '0;
      r_drain <= '0;
      r_addr  <= '0;
      r_vld   <= '0;
      r_peak  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int b = 0; b < 8; b++) r_bins[b] <= '0;
    end else begin
      r_vld  <= {r_vld[READ_LATENCY-1:0], w_issue && w_inb};
      r_done <= 1'b0;
      if (w_issue) begin
        r_oc <= w_wrap ? '0 : w_oc + 1'b1;
        r_or <= w_wrap ? w_or + 1'b1 : w_or;
        if (w_inb) r_addr <= AW'(w_row*32'(WIDTH) + w_col);
      end
      if (r_vld[READ_LATENCY] && w_nz) r_bins[w_bin] <= w_sat;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x     <= x;
            r_y     <= y;
            r_mode  <= weight_mode_in;
            r_cnt   <= CNTW'(1);
            r_peak  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
            for (int b = 0; b < 8; b++) r_bins[b] <= '0;
          end
        end
        S_SCAN: begin
          if (r_cnt == CNTW'(N)) begin
            r_drain <= DW'(1);
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_drain == DW'(READ_LATENCY)) r_state <= S_PEAK;
          else r_drain <= r_drain + 1'b1;
        end
        S_PEAK: begin
          r_peak  <= w_peak;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    histogram_out = '0;
    for (int b = 0; b < 8; b++)
      histogram_out[b*BIN_WIDTH +: BIN_WIDTH] = r_bins[b];
  end

  assign x_read_addr    = r_addr;
  assign y_read_addr    = r_addr;
  assign peak_bin_out   = r_peak;
  assign busy           = r_busy;
  assign histogram_done = r_done;

endmodule
